// File: rtl/mod_i2s_tx_stream.sv
// I2S / left-justified stereo serializer fed by a one-entry left/right holding buffer.
// Latency: an accepted pair starts shifting out at the next frame load (d==0), MSB first.
// Backpressure: o_ready is low while the buffer holds a pair; an empty buffer at load sends zeros.
module mod_i2s_tx_stream #(
    parameter int CLK_DIV  = 16,
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int MODE     = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [SAMPLE_W-1:0] i_left,
    input  logic [SAMPLE_W-1:0] i_right,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_sck,
    output logic                o_ws,
    output logic                o_sd,
    output logic                o_underrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);

    generate
        if (SLOT_W < SAMPLE_W) begin : g_bad_slot
            $error("SLOT_W must be >= SAMPLE_W");
        end
        if (CLK_DIV < 1 || CLK_DIV > 256) begin : g_bad_div
            $error("CLK_DIV must be in 1..256");
        end
        if (SAMPLE_W < 8 || SAMPLE_W > 32) begin : g_bad_sample
            $error("SAMPLE_W must be in 8..32");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("MODE must be 0 or 1");
        end
    endgenerate

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    logic [DW-1:0]       div_cnt;
    logic                sck_q;
    logic [BW-1:0]       b_q;
    logic                ws_q;
    logic                sd_q;
    logic                und_q;
    logic                buf_full;
    pair_t               buf_dat;
    pair_t               frame_q;

    logic                tick;
    logic                fall;
    logic                accept;
    logic                load;
    logic [BW-1:0]       b_nxt;
    logic [BW-1:0]       d_nxt;
    logic [BW-1:0]       k;
    logic                chan_right;
    pair_t               frame_nxt;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] shifted;
    logic                sd_nxt;

    always_comb begin
        tick   = (div_cnt == DIV_LAST);
        fall   = tick & sck_q;
        accept = i_valid & ~buf_full;
        b_nxt  = (b_q == B_LAST) ? '0 : b_q + BW'(1);
        if (MODE == 1) begin
            d_nxt = b_nxt;
        end else begin
            d_nxt = (b_nxt == '0) ? B_LAST : b_nxt - BW'(1);
        end
        load = fall & (d_nxt == '0);
        // The bit driven at the load fall must already come from the new frame
        frame_nxt = frame_q;
        if (load) begin
            frame_nxt = buf_full ? buf_dat : '0;
        end
        chan_right = (d_nxt >= SLOT_B);
        k          = chan_right ? d_nxt - SLOT_B : d_nxt;
        sample     = chan_right ? frame_nxt.right : frame_nxt.left;
        // Shifting by k >= SAMPLE_W empties the word, giving the zero padding for free
        shifted    = sample << k;
        sd_nxt     = shifted[SAMPLE_W-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt  <= '0;
            sck_q    <= 1'b0;
            b_q      <= B_LAST;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            und_q    <= 1'b0;
            buf_full <= 1'b0;
            buf_dat  <= '0;
            frame_q  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                sck_q <= ~sck_q;
            end
            und_q <= load & ~buf_full;
            if (fall) begin
                b_q     <= b_nxt;
                ws_q    <= (b_nxt >= SLOT_B);
                sd_q    <= sd_nxt;
                frame_q <= frame_nxt;
            end
            // An acceptance coinciding with an underrun load stays buffered for the next frame
            if (load && buf_full) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
                buf_dat  <= '{left: i_left, right: i_right};
            end
        end
    end

    assign o_ready    = ~buf_full;
    assign o_sck      = sck_q;
    assign o_ws       = ws_q;
    assign o_sd       = sd_q;
    assign o_underrun = und_q;

endmodule
